// File: rtl/l1tlb_passthrough.sv
// L1 TLB passthrough: identity translation of per-port core requests into
// per-port 2-entry forward buffers, with a prefetch queue whose entries are
// injected into idle ports and, under starvation, into a claimed port.
module l1tlb_passthrough #(
    parameter int NPORTS     = 2,
    parameter int LADDR_W    = 48,
    parameter int VA_W       = 39,
    parameter int PAGE_LSB   = 12,
    parameter int HPADDR_W   = 11,
    parameter int PPADDR_W   = 3,
    parameter int CID_W      = 2,
    parameter int PF_DEPTH   = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NPORTS-1:0]            core_valid,
    output logic [NPORTS-1:0]            core_retry,
    input  logic [NPORTS*LADDR_W-1:0]    core_laddr,
    input  logic [NPORTS*CID_W-1:0]      core_coreid,
    input  logic                         pfe_valid,
    output logic                         pfe_retry,
    input  logic [LADDR_W-1:0]           pfe_laddr,
    input  logic                         pfe_l2,
    output logic [NPORTS-1:0]            fwd_valid,
    input  logic [NPORTS-1:0]            fwd_retry,
    output logic [NPORTS*CID_W-1:0]      fwd_coreid,
    output logic [NPORTS-1:0]            fwd_prefetch,
    output logic [NPORTS-1:0]            fwd_fault,
    output logic [NPORTS*HPADDR_W-1:0]   fwd_hpaddr,
    output logic [NPORTS*PPADDR_W-1:0]   fwd_ppaddr
);

    localparam int RR_W     = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int PF_PTR_W = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
    localparam int PF_CNT_W = $clog2(PF_DEPTH + 1);
    localparam int ST_W     = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [CID_W-1:0]    coreid;
        logic                prefetch;
        logic                fault;
        logic [HPADDR_W-1:0] hpaddr;
        logic [PPADDR_W-1:0] ppaddr;
    } entry_t;

    // Identity translation: page-number slices plus a fault flag for any
    // address bit above the implemented VA range.
    function automatic entry_t translate(input logic [LADDR_W-1:0] laddr,
                                         input logic [CID_W-1:0]   cid,
                                         input logic               is_pf);
        entry_t e;
        e.coreid   = cid;
        e.prefetch = is_pf;
        e.fault    = |laddr[LADDR_W-1:VA_W];
        e.hpaddr   = laddr[PAGE_LSB+HPADDR_W-1:PAGE_LSB];
        e.ppaddr   = laddr[PAGE_LSB+PPADDR_W-1:PAGE_LSB];
        return e;
    endfunction

    function automatic logic [PF_PTR_W-1:0] pf_next(input logic [PF_PTR_W-1:0] p);
        return (p == PF_PTR_W'(PF_DEPTH - 1)) ? '0 : p + PF_PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Shared state
    // ------------------------------------------------------------------
    logic [LADDR_W-1:0]  pf_mem [PF_DEPTH];
    logic [PF_PTR_W-1:0] pf_head;
    logic [PF_PTR_W-1:0] pf_tail;
    logic [PF_CNT_W-1:0] pf_count;
    logic                pf_enq;
    logic                pf_empty;

    logic [RR_W-1:0]     rr_ptr;
    logic [ST_W-1:0]     starve_cnt;
    logic                claimed;

    logic [NPORTS-1:0]   buf_full;
    logic                inj_valid;
    logic [RR_W-1:0]     inj_port;
    logic [RR_W:0]       idx_wide;
    logic [RR_W-1:0]     idx;

    assign pf_empty  = (pf_count == '0);
    assign pfe_retry = (pf_count == PF_CNT_W'(PF_DEPTH));
    assign pf_enq    = pfe_valid & ~pfe_retry & ~pfe_l2;
    assign claimed   = (starve_cnt == ST_W'(STARVE_MAX));

    // Pick the port that receives the prefetch head this cycle, if any.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        inj_valid = 1'b0;
        inj_port  = '0;
        idx_wide  = '0;
        idx       = '0;
        if (!pf_empty) begin
            if (claimed) begin
                // The claimed port's core side is held off; wait only for space.
                if (!buf_full[rr_ptr]) begin
                    inj_valid = 1'b1;
                    inj_port  = rr_ptr;
                end
            end else begin
                for (int k = 0; k < NPORTS; k++) begin
                    idx_wide = {1'b0, rr_ptr} + (RR_W+1)'(k);
                    if (idx_wide >= (RR_W+1)'(NPORTS)) begin
                        idx_wide = idx_wide - (RR_W+1)'(NPORTS);
                    end
                    idx = idx_wide[RR_W-1:0];
                    if (!inj_valid && !core_valid[idx] && !buf_full[idx]) begin
                        inj_valid = 1'b1;
                        inj_port  = idx;
                    end
                end
            end
        end
    end

    // Prefetch queue pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            pf_head  <= '0;
            pf_tail  <= '0;
            pf_count <= '0;
        end else begin
            if (pf_enq) pf_tail <= pf_next(pf_tail);
            if (inj_valid) pf_head <= pf_next(pf_head);
            case ({pf_enq, inj_valid})
                2'b10:   pf_count <= pf_count + PF_CNT_W'(1);
                2'b01:   pf_count <= pf_count - PF_CNT_W'(1);
                default: pf_count <= pf_count;
            endcase
        end
    end

    // Prefetch queue storage.
    // NOTE: data arrays are not reset; occupancy counters alone decide what is valid.
    always_ff @(posedge clk) begin
        if (pf_enq) pf_mem[pf_tail] <= pfe_laddr;
    end

    // Round-robin pointer advances past each port that receives a prefetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (inj_valid) begin
            rr_ptr <= (inj_port == RR_W'(NPORTS - 1)) ? '0 : inj_port + RR_W'(1);
        end
    end

    // Starvation counter: counts cycles a queued prefetch waits, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (inj_valid || pf_empty) begin
            starve_cnt <= '0;
        end else if (!claimed) begin
            starve_cnt <= starve_cnt + ST_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-port 2-entry forward buffers
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        entry_t     mem [2];
        logic       rd_ptr;
        logic       wr_ptr;
        logic [1:0] count;
        logic       enq_core;
        logic       enq_pf;
        logic       enq;
        logic       deq;
        entry_t     enq_data;
        entry_t     head;

        assign buf_full[i]   = (count == 2'd2);
        assign core_retry[i] = buf_full[i] | (claimed & (rr_ptr == RR_W'(i)));
        assign enq_core      = core_valid[i] & ~core_retry[i];
        assign enq_pf        = inj_valid & (inj_port == RR_W'(i));
        assign enq           = enq_core | enq_pf;
        assign deq           = (count != 2'd0) & ~fwd_retry[i];

        // A forced or opportunistic injection never coincides with a core
        // accept on the same port, so the prefetch select is unambiguous.
        assign enq_data = enq_pf
            ? translate(pf_mem[pf_head], '0, 1'b1)
            : translate(core_laddr[i*LADDR_W +: LADDR_W], core_coreid[i*CID_W +: CID_W], 1'b0);

        // Buffer storage.
        always_ff @(posedge clk) begin
            if (enq) mem[wr_ptr] <= enq_data;
        end

        // Buffer pointers and occupancy.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (enq) wr_ptr <= ~wr_ptr;
                if (deq) rd_ptr <= ~rd_ptr;
                case ({enq, deq})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end

        // Payload reads as zero whenever the buffer is empty.
        assign head = (count != 2'd0) ? mem[rd_ptr] : '0;

        assign fwd_valid[i]                         = (count != 2'd0);
        assign fwd_coreid[i*CID_W +: CID_W]         = head.coreid;
        assign fwd_prefetch[i]                      = head.prefetch;
        assign fwd_fault[i]                         = head.fault;
        assign fwd_hpaddr[i*HPADDR_W +: HPADDR_W]   = head.hpaddr;
        assign fwd_ppaddr[i*PPADDR_W +: PPADDR_W]   = head.ppaddr;
    end

endmodule
